coreriscv_axi4_uncached_xact_tracker: RTL and testbench
=======================================================

CORERISCV_AXI4_UNCACHED_XACT_TRACKER -- requirements
Module: coreriscv_axi4_uncached_xact_tracker

Interface
REQ-001 SHALL have parameter: BEATS, 8, data beats per block (power of 2; addr_beat width 3 at default).
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: c_acq_valid in 1 / c_acq_ready out 1  client acquire handshake.
REQ-005 SHALL have ports: c_acq_addr_block in 26, c_acq_xact_id in 1, c_acq_addr_beat in 3, c_acq_is_builtin in 1, c_acq_a_type in 3, c_acq_union in 12, c_acq_data in 64  client acquire payload.
REQ-006 SHALL have ports: n_acq_valid out 1 / n_acq_ready in 1 plus n_acq_* out, same widths as REQ-005  acquire toward network port.
REQ-007 SHALL have ports: n_gnt_valid in 1 / n_gnt_ready out 1, n_gnt_addr_beat in 3, n_gnt_xact_id in 1, n_gnt_g_type in 4, n_gnt_data in 64  grant from network port.
REQ-008 SHALL have ports: c_gnt_valid out 1 / c_gnt_ready in 1 plus c_gnt_* out, same widths as REQ-007  grant to client.
REQ-009 SHALL have ports: busy out 2 (one bit per xact id), err out 1 (sticky protocol error).

Function
REQ-010 Acquire and grant payloads SHALL pass through combinationally unmodified; zero added latency.
REQ-011 Transaction class from a_type: 1 = GET_BLOCK (1 acquire beat, BEATS grant beats); 3 = PUT_BLOCK (BEATS acquire beats, 1 grant beat); all other values = SINGLE (1/1).
REQ-012 Per id i: slot state IDLE, ACQ (put-block beats outstanding), WAIT_GNT; busy[i] = (state != IDLE).
REQ-013 First acquire beat for id i SHALL be forwarded only when slot i is IDLE and no put-block is locked; otherwise n_acq_valid=0 and c_acq_ready=0.
REQ-014 c_acq_ready SHALL equal n_acq_ready AND the REQ-013/REQ-015 gate; n_acq_valid SHALL equal c_acq_valid AND the same gate.
REQ-015 Put-block lock: after the first PUT_BLOCK beat fires, only beats with the locked id SHALL pass until BEATS beats have fired; other ids stall.
REQ-016 Acquire beat counter: 3 bits, increments per fired put-block beat, wraps BEATS-1 -> 0; wrap releases the lock and moves the slot ACQ -> WAIT_GNT.
REQ-017 SINGLE or GET_BLOCK first-beat fire SHALL move slot IDLE -> WAIT_GNT in one cycle; PUT_BLOCK with BEATS=1 degenerates likewise.
REQ-018 Per-slot grant beat counter (3 bits) increments on each c_gnt fire (c_gnt_valid & c_gnt_ready) for that id.
REQ-019 Slot SHALL return to IDLE on the fire of its last grant beat: counter == BEATS-1 for GET_BLOCK, first beat otherwise; counter clears to 0.
REQ-020 c_gnt_valid = n_gnt_valid; n_gnt_ready = c_gnt_ready; grants are never blocked.
REQ-021 Grant fire for an id whose slot is not WAIT_GNT SHALL set err=1 (sticky until reset) and leave slot state unchanged.
REQ-022 Same-cycle acquire fire and grant-completion on the same id: completion applies first, the new acquire is not accepted that cycle (slot not IDLE at gate evaluation); different ids SHALL update independently.
REQ-023 An acquire beat whose id differs from the locked id during a put-block lock SHALL NOT set err; it stalls.

Reset
REQ-024 While reset=0 at a rising edge: both slots IDLE, all counters 0, lock cleared, err=0, busy=2'b00.
REQ-025 Outputs during reset: n_acq_valid=0, c_acq_ready=0; grant path remains combinational pass-through.
REQ-026 Reset mid-transaction SHALL abandon all state without err; first grant after reset for that id SHALL set err.

Verification
REQ-027 SINGLE get id0: acquire fires cycle 0 -> busy=01; grant beat0 fires cycle 3 -> busy=00 next cycle, err=0.
REQ-028 GET_BLOCK id1 with 8 grant beats, c_gnt_ready toggling 1/0 -> busy[1] clears only after 8th fire; second acquire id1 stalled (c_acq_ready=0) throughout.
REQ-029 PUT_BLOCK id0, 8 beats, interleaved id1 acquire attempt on beat 3 -> id1 stalls until beat 7 fires, then forwarded; err=0.
REQ-030 Unsolicited grant id1 while busy=00 -> err=1 next cycle and stays 1 through further legal traffic.
REQ-031 reset=0 asserted during beat 4 of GET_BLOCK id0 -> busy=00, counters 0; next grant id0 -> err=1.
REQ-032 Same-cycle last grant id0 and new acquire id0 -> acquire not accepted that cycle, accepted next cycle, busy[0] stays 1.

Source files
------------

// File: rtl/coreriscv_axi4_uncached_xact_tracker.sv
// coreriscv_axi4_uncached_xact_tracker: per-id uncached transaction tracking between client and network ports
module coreriscv_axi4_uncached_xact_tracker #(
    parameter int BEATS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_acq_valid,
    output logic        c_acq_ready,
    input  logic [25:0] c_acq_addr_block,
    input  logic        c_acq_xact_id,
    input  logic [2:0]  c_acq_addr_beat,
    input  logic        c_acq_is_builtin,
    input  logic [2:0]  c_acq_a_type,
    input  logic [11:0] c_acq_union,
    input  logic [63:0] c_acq_data,
    output logic        n_acq_valid,
    input  logic        n_acq_ready,
    output logic [25:0] n_acq_addr_block,
    output logic        n_acq_xact_id,
    output logic [2:0]  n_acq_addr_beat,
    output logic        n_acq_is_builtin,
    output logic [2:0]  n_acq_a_type,
    output logic [11:0] n_acq_union,
    output logic [63:0] n_acq_data,
    input  logic        n_gnt_valid,
    output logic        n_gnt_ready,
    input  logic [2:0]  n_gnt_addr_beat,
    input  logic        n_gnt_xact_id,
    input  logic [3:0]  n_gnt_g_type,
    input  logic [63:0] n_gnt_data,
    output logic        c_gnt_valid,
    input  logic        c_gnt_ready,
    output logic [2:0]  c_gnt_addr_beat,
    output logic        c_gnt_xact_id,
    output logic [3:0]  c_gnt_g_type,
    output logic [63:0] c_gnt_data,
    output logic [1:0]  busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ACQ, WAIT_GNT} slot_e;
    localparam logic [2:0] LAST = 3'(BEATS - 1);
    slot_e      state_q [2];
    slot_e      state_n [2];
    logic [2:0] gcnt_q [2];
    logic [2:0] gcnt_n [2];
    logic       get_q [2];
    logic       get_n [2];
    logic [2:0] acnt_q, acnt_n;
    logic       lock_q, lock_n, lock_id_q, lock_id_n, err_q, err_n;
    logic       gate, acq_fire, gnt_fire, is_put, is_get, a_done, g_last;

    assign n_acq_addr_block = c_acq_addr_block;
    assign n_acq_xact_id    = c_acq_xact_id;
    assign n_acq_addr_beat  = c_acq_addr_beat;
    assign n_acq_is_builtin = c_acq_is_builtin;
    assign n_acq_a_type     = c_acq_a_type;
    assign n_acq_union      = c_acq_union;
    assign n_acq_data       = c_acq_data;
    assign c_gnt_valid      = n_gnt_valid;
    assign n_gnt_ready      = c_gnt_ready;
    assign c_gnt_addr_beat  = n_gnt_addr_beat;
    assign c_gnt_xact_id    = n_gnt_xact_id;
    assign c_gnt_g_type     = n_gnt_g_type;
    assign c_gnt_data       = n_gnt_data;
    assign busy             = {state_q[1] != IDLE, state_q[0] != IDLE};
    assign err              = err_q;

    // acquire gate: locked put-block id only, else a first beat needs an idle slot
    always_comb begin
        gate        = reset && (lock_q ? (c_acq_xact_id == lock_id_q) : (state_q[c_acq_xact_id] == IDLE));
        c_acq_ready = n_acq_ready && gate;
        n_acq_valid = c_acq_valid && gate;
        acq_fire    = c_acq_valid && n_acq_ready && gate;
        gnt_fire    = n_gnt_valid && c_gnt_ready;
        is_put      = c_acq_a_type == 3'd3;
        is_get      = c_acq_a_type == 3'd1;
        a_done      = acnt_q == LAST;
        g_last      = !get_q[n_gnt_xact_id] || (gcnt_q[n_gnt_xact_id] == LAST);
    end

    // slot next state: grant completion applied before acquire acceptance
    always_comb begin
        state_n   = state_q;
        gcnt_n    = gcnt_q;
        get_n     = get_q;
        acnt_n    = acnt_q;
        lock_n    = lock_q;
        lock_id_n = lock_id_q;
        err_n     = err_q;
        if (gnt_fire) begin
            if (state_q[n_gnt_xact_id] != WAIT_GNT) begin
                err_n = 1'b1;
            end else if (g_last) begin
                state_n[n_gnt_xact_id] = IDLE;
                gcnt_n[n_gnt_xact_id]  = 3'd0;
            end else begin
                gcnt_n[n_gnt_xact_id] = gcnt_q[n_gnt_xact_id] + 3'd1;
            end
        end
        if (acq_fire) begin
            if (!lock_q) get_n[c_acq_xact_id] = is_get;
            if (lock_q || is_put) begin
                acnt_n                 = a_done ? 3'd0 : acnt_q + 3'd1;
                lock_n                 = !a_done;
                lock_id_n              = c_acq_xact_id;
                state_n[c_acq_xact_id] = a_done ? WAIT_GNT : ACQ;
            end else begin
                state_n[c_acq_xact_id] = WAIT_GNT;
            end
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= '{IDLE, IDLE};
            gcnt_q    <= '{3'd0, 3'd0};
            get_q     <= '{1'b0, 1'b0};
            acnt_q    <= 3'd0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            gcnt_q    <= gcnt_n;
            get_q     <= get_n;
            acnt_q    <= acnt_n;
            lock_q    <= lock_n;
            lock_id_q <= lock_id_n;
            err_q     <= err_n;
        end
    end
endmodule

// File: tb/tb_coreriscv_axi4_uncached_xact_tracker.sv
// tb_coreriscv_axi4_uncached_xact_tracker: scoreboard bench for the uncached transaction tracker
module tb_coreriscv_axi4_uncached_xact_tracker;
    logic        clk = 0;
    logic        reset;
    logic        c_acq_valid, c_acq_ready;
    logic [25:0] c_acq_addr_block;
    logic        c_acq_xact_id;
    logic [2:0]  c_acq_addr_beat;
    logic        c_acq_is_builtin;
    logic [2:0]  c_acq_a_type;
    logic [11:0] c_acq_union;
    logic [63:0] c_acq_data;
    logic        n_acq_valid, n_acq_ready;
    logic [25:0] n_acq_addr_block;
    logic        n_acq_xact_id;
    logic [2:0]  n_acq_addr_beat;
    logic        n_acq_is_builtin;
    logic [2:0]  n_acq_a_type;
    logic [11:0] n_acq_union;
    logic [63:0] n_acq_data;
    logic        n_gnt_valid, n_gnt_ready;
    logic [2:0]  n_gnt_addr_beat;
    logic        n_gnt_xact_id;
    logic [3:0]  n_gnt_g_type;
    logic [63:0] n_gnt_data;
    logic        c_gnt_valid, c_gnt_ready;
    logic [2:0]  c_gnt_addr_beat;
    logic        c_gnt_xact_id;
    logic [3:0]  c_gnt_g_type;
    logic [63:0] c_gnt_data;
    logic [1:0]  busy;
    logic        err;
    int          vectors = 0;
    int          miscompares = 0;
    logic [109:0] acq_q[$];
    logic [71:0]  gnt_q[$];

    coreriscv_axi4_uncached_xact_tracker #(.BEATS(8)) dut (
        .clk(clk), .reset(reset),
        .c_acq_valid(c_acq_valid), .c_acq_ready(c_acq_ready),
        .c_acq_addr_block(c_acq_addr_block), .c_acq_xact_id(c_acq_xact_id),
        .c_acq_addr_beat(c_acq_addr_beat), .c_acq_is_builtin(c_acq_is_builtin),
        .c_acq_a_type(c_acq_a_type), .c_acq_union(c_acq_union), .c_acq_data(c_acq_data),
        .n_acq_valid(n_acq_valid), .n_acq_ready(n_acq_ready),
        .n_acq_addr_block(n_acq_addr_block), .n_acq_xact_id(n_acq_xact_id),
        .n_acq_addr_beat(n_acq_addr_beat), .n_acq_is_builtin(n_acq_is_builtin),
        .n_acq_a_type(n_acq_a_type), .n_acq_union(n_acq_union), .n_acq_data(n_acq_data),
        .n_gnt_valid(n_gnt_valid), .n_gnt_ready(n_gnt_ready),
        .n_gnt_addr_beat(n_gnt_addr_beat), .n_gnt_xact_id(n_gnt_xact_id),
        .n_gnt_g_type(n_gnt_g_type), .n_gnt_data(n_gnt_data),
        .c_gnt_valid(c_gnt_valid), .c_gnt_ready(c_gnt_ready),
        .c_gnt_addr_beat(c_gnt_addr_beat), .c_gnt_xact_id(c_gnt_xact_id),
        .c_gnt_g_type(c_gnt_g_type), .c_gnt_data(c_gnt_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [109:0] acq_vec(input logic id, input logic [2:0] ty, input logic [2:0] beat, input logic [63:0] d);
        return {26'h12345, id, beat, 1'b1, ty, 12'h0A5, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acq(input logic v, input logic id, input logic [2:0] ty, input logic [2:0] beat, input logic [63:0] d);
        c_acq_valid = v; c_acq_xact_id = id; c_acq_a_type = ty; c_acq_addr_beat = beat; c_acq_data = d;
        c_acq_addr_block = 26'h12345; c_acq_is_builtin = 1'b1; c_acq_union = 12'h0A5;
    endtask

    task automatic set_gnt(input logic id, input logic [2:0] beat, input logic [63:0] d);
        n_gnt_valid = 1'b1; n_gnt_xact_id = id; n_gnt_addr_beat = beat; n_gnt_g_type = 4'h5; n_gnt_data = d;
    endtask

    task automatic send_acq(input logic id, input logic [2:0] ty, input logic [2:0] beat, input logic [63:0] d);
        int n = 0;
        set_acq(1'b1, id, ty, beat, d);
        #1;
        while (!c_acq_ready && n < 40) begin
            tick();
            n++;
        end
        chk("acq_accept", c_acq_ready, 1);
        acq_q.push_back(acq_vec(id, ty, beat, d));
        tick();
        c_acq_valid = 1'b0;
    endtask

    task automatic send_gnt(input logic id, input logic [2:0] beat, input logic [63:0] d);
        set_gnt(id, beat, d);
        c_gnt_ready = 1'b1;
        gnt_q.push_back({beat, id, 4'h5, d});
        tick();
        n_gnt_valid = 1'b0;
    endtask

    // acquire monitor: every beat forwarded to the network is scored
    always @(negedge clk) begin
        if (n_acq_valid && n_acq_ready) begin
            if (acq_q.size() == 0) chk("acq_unexpected", 1, 0);
            else chk("acq_payload", {n_acq_addr_block, n_acq_xact_id, n_acq_addr_beat, n_acq_is_builtin, n_acq_a_type, n_acq_union, n_acq_data}, acq_q.pop_front());
        end
    end

    // grant monitor: every grant delivered to the client is scored
    always @(negedge clk) begin
        if (c_gnt_valid && c_gnt_ready) begin
            if (gnt_q.size() == 0) chk("gnt_unexpected", 1, 0);
            else chk("gnt_payload", {c_gnt_addr_beat, c_gnt_xact_id, c_gnt_g_type, c_gnt_data}, gnt_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; n_acq_ready = 1; c_gnt_ready = 0; n_gnt_valid = 0;
        n_gnt_xact_id = 0; n_gnt_addr_beat = 0; n_gnt_g_type = 0; n_gnt_data = 0;
        set_acq(1'b1, 1'b0, 3'd0, 3'd0, 64'h1);
        set_gnt(1'b0, 3'd2, 64'hDEAD_BEEF);
        tick(); tick();
        chk("rst_n_acq_valid", n_acq_valid, 0);
        chk("rst_c_acq_ready", c_acq_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_c_gnt_valid", c_gnt_valid, 1);
        chk("rst_c_gnt_data", c_gnt_data, 64'hDEAD_BEEF);
        chk("rst_n_gnt_ready", n_gnt_ready, 0);
        c_acq_valid = 0; n_gnt_valid = 0; c_gnt_ready = 1; reset = 1;
        tick();
        // single get id0, with a network back-pressure cycle first
        set_acq(1'b1, 1'b0, 3'd0, 3'd0, 64'hA0);
        n_acq_ready = 0;
        #1;
        chk("bp_c_acq_ready", c_acq_ready, 0);
        chk("bp_n_acq_valid", n_acq_valid, 1);
        n_acq_ready = 1;
        send_acq(1'b0, 3'd0, 3'd0, 64'hA0);
        chk("single_busy", busy, 2'b01);
        tick(); tick();
        send_gnt(1'b0, 3'd0, 64'hB0);
        chk("single_done", busy, 2'b00);
        chk("single_err", err, 0);
        // get-block id1, 8 grant beats with ready toggling, second id1 acquire stalled
        send_acq(1'b1, 3'd1, 3'd0, 64'h11);
        chk("get_busy0", busy, 2'b10);
        set_acq(1'b1, 1'b1, 3'd0, 3'd0, 64'h22);
        for (int k = 0; k < 8; k++) begin
            set_gnt(1'b1, 3'(k), 64'hC0 + 64'(k));
            c_gnt_ready = 0;
            #1;
            chk("get_stall", c_acq_ready, 0);
            tick();
            c_gnt_ready = 1;
            #1;
            chk("get_stall", c_acq_ready, 0);
            chk("get_busy", busy, 2'b10);
            gnt_q.push_back({3'(k), 1'b1, 4'h5, 64'hC0 + 64'(k)});
            tick();
        end
        n_gnt_valid = 0;
        chk("get_done", busy, 2'b00);
        chk("get_release", c_acq_ready, 1);
        acq_q.push_back(acq_vec(1'b1, 3'd0, 3'd0, 64'h22));
        tick();
        c_acq_valid = 0;
        chk("get_next_busy", busy, 2'b10);
        send_gnt(1'b1, 3'd0, 64'hC8);
        chk("get_next_done", busy, 2'b00);
        // put-block id0 with an id1 attempt inside the lock
        for (int b = 0; b < 3; b++) send_acq(1'b0, 3'd3, 3'(b), 64'hD0 + 64'(b));
        chk("put_busy", busy, 2'b01);
        set_acq(1'b1, 1'b1, 3'd0, 3'd0, 64'h33);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("put_lock_ready", c_acq_ready, 0);
            chk("put_lock_valid", n_acq_valid, 0);
            tick();
        end
        for (int b = 3; b < 8; b++) send_acq(1'b0, 3'd3, 3'(b), 64'hD0 + 64'(b));
        chk("put_wait", busy, 2'b01);
        send_acq(1'b1, 3'd0, 3'd0, 64'h33);
        chk("put_both", busy, 2'b11);
        chk("put_err", err, 0);
        send_gnt(1'b0, 3'd0, 64'hE0);
        chk("put_done", busy, 2'b10);
        send_gnt(1'b1, 3'd0, 64'hE1);
        chk("put_all_done", busy, 2'b00);
        // same-cycle last grant and new acquire on id0
        send_acq(1'b0, 3'd0, 3'd0, 64'h44);
        set_gnt(1'b0, 3'd0, 64'hF0);
        set_acq(1'b1, 1'b0, 3'd0, 3'd0, 64'h55);
        #1;
        chk("same_blocked", c_acq_ready, 0);
        gnt_q.push_back({3'd0, 1'b0, 4'h5, 64'hF0});
        tick();
        n_gnt_valid = 0;
        #1;
        chk("same_next", c_acq_ready, 1);
        acq_q.push_back(acq_vec(1'b0, 3'd0, 3'd0, 64'h55));
        tick();
        c_acq_valid = 0;
        chk("same_busy", busy, 2'b01);
        send_gnt(1'b0, 3'd0, 64'hF1);
        chk("same_done", busy, 2'b00);
        chk("same_err", err, 0);
        // unsolicited grant makes err sticky
        send_gnt(1'b1, 3'd0, 64'h99);
        chk("unsol_err", err, 1);
        chk("unsol_busy", busy, 2'b00);
        send_acq(1'b0, 3'd0, 3'd0, 64'h66);
        send_gnt(1'b0, 3'd0, 64'h67);
        chk("unsol_sticky", err, 1);
        // reset in the middle of a get-block
        reset = 0;
        tick(); tick();
        reset = 1;
        chk("rst2_err", err, 0);
        send_acq(1'b0, 3'd1, 3'd0, 64'h77);
        for (int k = 0; k < 4; k++) send_gnt(1'b0, 3'(k), 64'h70 + 64'(k));
        chk("mid_busy", busy, 2'b01);
        set_gnt(1'b0, 3'd4, 64'h74);
        gnt_q.push_back({3'd4, 1'b0, 4'h5, 64'h74});
        reset = 0;
        tick();
        n_gnt_valid = 0;
        reset = 1;
        chk("mid_rst_busy", busy, 2'b00);
        chk("mid_rst_err", err, 0);
        send_gnt(1'b0, 3'd5, 64'h75);
        chk("mid_rst_late_gnt", err, 1);
        tick(); tick();
        chk("acq_q_empty", acq_q.size(), 0);
        chk("gnt_q_empty", gnt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
